// File: rtl/tpu_apb_regfile_if.sv
// APB bus bundle between the host master and the TPU control register file.
// Handshake: a transfer is one setup cycle (psel=1, penable=0) followed by one
// access cycle (psel=1, penable=1); there is no wait-state or error response,
// so every well-formed transfer completes in exactly two cycles.
interface tpu_apb_regfile_if;
  logic [31:0] i_paddr;
  logic        i_psel;
  logic        i_penable;
  logic        i_pwrite;
  logic [31:0] i_pwdata;
  logic [31:0] o_prdata;

  modport master (
    output i_paddr, i_psel, i_penable, i_pwrite, i_pwdata,
    input  o_prdata
  );

  modport slave (
    input  i_paddr, i_psel, i_penable, i_pwrite, i_pwdata,
    output o_prdata
  );
endinterface

// File: rtl/tpu_apb_regfile.sv
// TPU control/status register file behind a fixed two-cycle APB responder.
// Writes commit on the setup->access edge; read data is registered on the
// setup edge so it is stable for the master at the end of the access phase.
module tpu_apb_regfile #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [31:0] ID_VALUE  = 32'h5450_0404
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  tpu_apb_regfile_if.slave apb,
  input  logic         i_busy,
  input  logic         i_done,
  output logic         o_start,
  output logic         o_soft_rst,
  output logic [7:0]   o_mode,
  output logic [127:0] o_cfg,
  output logic         o_irq,
  output logic [1:0]   o_dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  state_t state, state_n;

  logic        setup_go;   // entering SETUP from IDLE or ACCESS
  logic        commit;     // SETUP -> ACCESS edge
  logic        proto_err;  // penable without a preceding setup
  logic        hit;
  logic [31:0] rdata;

  logic        irq_en;
  logic        done;
  logic [31:0] scratch;
  logic [15:0] err_cnt;

  // Address decode: inside the 256-byte window, word aligned, at or below ERR_CNT.
  assign hit = (apb.i_paddr[31:8] == BASE_ADDR[31:8]) &&
               (apb.i_paddr[1:0] == 2'b00) &&
               (apb.i_paddr[7:0] <= 8'h24);

  assign o_dbg_state = state;

  // Phase tracking: next state and the edge events derived from it.
  always_comb begin
    state_n   = state;
    setup_go  = 1'b0;
    commit    = 1'b0;
    proto_err = 1'b0;
    case (state)
      ST_IDLE: begin
        if (apb.i_psel && !apb.i_penable) begin
          state_n  = ST_SETUP;
          setup_go = 1'b1;
        end else if (apb.i_psel && apb.i_penable) begin
          proto_err = 1'b1;
        end
      end
      ST_SETUP: begin
        if (!apb.i_psel) begin
          state_n = ST_IDLE;
        end else if (apb.i_penable) begin
          state_n = ST_ACCESS;
          commit  = 1'b1;
        end
      end
      ST_ACCESS: begin
        if (!apb.i_psel) begin
          state_n = ST_IDLE;
        end else if (!apb.i_penable) begin
          state_n  = ST_SETUP;
          setup_go = 1'b1;
        end else begin
          state_n   = ST_IDLE;
          proto_err = 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Phase state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= ST_IDLE;
    else          state <= state_n;
  end

  // Read mux for the current address; unmapped addresses read as zero.
  always_comb begin
    rdata = 32'h0;
    if (hit) begin
      case (apb.i_paddr[5:2])
        4'd0:    rdata = ID_VALUE;
        4'd1:    rdata = {16'h0, o_mode, 8'h0};
        4'd2:    rdata = {30'h0, done, i_busy};
        4'd3:    rdata = {31'h0, irq_en};
        4'd4:    rdata = o_cfg[31:0];
        4'd5:    rdata = o_cfg[63:32];
        4'd6:    rdata = o_cfg[95:64];
        4'd7:    rdata = o_cfg[127:96];
        4'd8:    rdata = scratch;
        4'd9:    rdata = {16'h0, err_cnt};
        default: rdata = 32'h0;
      endcase
    end
  end

  logic wr_commit;
  assign wr_commit = commit && apb.i_pwrite && hit;

  // Register file: write commits, pulses, sticky done, error counter, irq.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      apb.o_prdata <= 32'h0;
      o_start      <= 1'b0;
      o_soft_rst   <= 1'b0;
      o_mode       <= 8'h0;
      o_cfg        <= 128'h0;
      o_irq        <= 1'b0;
      irq_en       <= 1'b0;
      done         <= 1'b0;
      scratch      <= 32'h0;
      err_cnt      <= 16'h0;
    end else begin
      if (setup_go && !apb.i_pwrite) apb.o_prdata <= rdata;

      o_start    <= wr_commit && (apb.i_paddr[5:2] == 4'd1) && apb.i_pwdata[0];
      o_soft_rst <= wr_commit && (apb.i_paddr[5:2] == 4'd1) && apb.i_pwdata[1];

      if (wr_commit) begin
        case (apb.i_paddr[5:2])
          4'd1:    o_mode         <= apb.i_pwdata[15:8];
          4'd3:    irq_en         <= apb.i_pwdata[0];
          4'd4:    o_cfg[31:0]    <= apb.i_pwdata;
          4'd5:    o_cfg[63:32]   <= apb.i_pwdata;
          4'd6:    o_cfg[95:64]   <= apb.i_pwdata;
          4'd7:    o_cfg[127:96]  <= apb.i_pwdata;
          4'd8:    scratch        <= apb.i_pwdata;
          default: ;
        endcase
      end

      // A new completion wins over a simultaneous write-one-to-clear.
      if (i_done)
        done <= 1'b1;
      else if (wr_commit && (apb.i_paddr[5:2] == 4'd2) && apb.i_pwdata[1])
        done <= 1'b0;

      // Clear wins over a simultaneous error; otherwise saturate at all-ones.
      if (wr_commit && (apb.i_paddr[5:2] == 4'd1) && apb.i_pwdata[2])
        err_cnt <= 16'h0;
      else if ((proto_err || (commit && !hit)) && (err_cnt != 16'hFFFF))
        err_cnt <= err_cnt + 16'd1;

      o_irq <= done && irq_en;
    end
  end

endmodule

// File: doc/tpu_apb_regfile.md
# tpu_apb_regfile

APB responder that terminates the TPU host-side control bus and implements the accelerator's control/status register file. It decodes APB setup/access phases from the testbench/host APB master (no PREADY/PSLVERR, fixed two-cycle transfers), commits writes into registers that drive the systolic-array controller, and returns read data in time for the master to sample it at the end of the access phase.

## Interface
- BASE_ADDR, 32'h0000_0000, block base; hit requires i_paddr[31:8] == BASE_ADDR[31:8]
- ID_VALUE, 32'h5450_0404, constant returned by the ID register
- i_clk  input  1  sole clock; all state on rising edge
- i_rst_n  input  1  asynchronous, active-low reset
- i_paddr  input  32  byte address
- i_psel  input  1  select
- i_penable  input  1  access-phase strobe
- i_pwrite  input  1  1 = write, 0 = read
- i_pwdata  input  32  write data
- o_prdata  output  32  read data, registered
- i_busy  input  1  live busy from TPU core
- i_done  input  1  one-cycle completion pulse from TPU core
- o_start  output  1  one-cycle start pulse
- o_soft_rst  output  1  one-cycle core soft-reset pulse
- o_mode  output  8  operating mode
- o_cfg  output  128  CFG3..CFG0 concatenated, CFG0 in [31:0]
- o_irq  output  1  done & irq_en, registered

## Operation
- Register map (offset from base, word-aligned):
  - 0x00 ID: RO, ID_VALUE
  - 0x04 CTRL: bit0 start (W, self-clearing → o_start), bit1 soft_rst (W → o_soft_rst), bit2 err_clr (W, clears ERR_CNT), [15:8] mode RW; pulse bits read 0
  - 0x08 STATUS: bit0 busy (RO, live i_busy), bit1 done (sticky, set by i_done, W1C)
  - 0x0C IRQ_EN: bit0 RW, other bits read 0
  - 0x10/0x14/0x18/0x1C CFG0..CFG3: RW 32-bit
  - 0x20 SCRATCH: RW 32-bit
  - 0x24 ERR_CNT: RO [15:0], saturating at 16'hFFFF
- Unmapped: base miss, offset > 0x24, or i_paddr[1:0] != 0. Reads return 0, writes ignored, ERR_CNT +1.
- Phase FSM (IDLE, SETUP, ACCESS), sampled each rising edge:
  - IDLE: psel & !penable → SETUP; psel & penable → protocol error, ERR_CNT +1, stay IDLE, no commit
  - SETUP: psel & penable → ACCESS (commit edge); !psel → IDLE (aborted, no commit); psel & !penable → stay SETUP
  - ACCESS: !psel → IDLE; psel & !penable → SETUP (back-to-back); psel & penable → IDLE, ERR_CNT +1
- Writes commit on the SETUP→ACCESS edge using address/data sampled at that edge.
- Reads: o_prdata loaded on the IDLE/ACCESS→SETUP edge (psel & !penable & !pwrite); held until next read load. Writes never change o_prdata.
- done: i_done and W1C on the same edge → done = 1 (set wins).
- ERR_CNT: err_clr and an error on the same edge → result 0.

## Timing
- Reset (async assert, synchronous-safe release): FSM IDLE; o_prdata, o_start, o_soft_rst, o_mode, o_cfg, o_irq, irq_en, done, SCRATCH, ERR_CNT = 0.
- Master transfer: setup edge E1, access edge E2, master samples o_prdata at E3. o_prdata is valid from just after E1, stable through E3.
- Write effects visible on outputs one cycle after E2 (o_start/o_soft_rst high for exactly the cycle after E2).
- o_irq updates one cycle after done or irq_en changes.
- Reset mid-transfer: in-flight write not committed; if reset releases with psel & penable high, treated as IDLE protocol error.
- Back-to-back transfers with no idle cycle supported.

## Test plan
- Reset, read 0x00 → o_prdata = 32'h5450_0404; read 0x20 → 0; all outputs 0 after reset.
- Write 0x10 = 32'hDEAD_BEEF, 0x1C = 32'h1234_5678 → o_cfg[31:0] = 32'hDEAD_BEEF, o_cfg[127:96] = 32'h1234_5678; readback matches.
- Write 0x04 = 32'h0000_A501 → o_start high exactly one cycle, o_mode = 8'hA5; read 0x04 → 32'h0000_A500.
- Pulse i_done with irq_en = 1 → STATUS reads 32'h2, o_irq = 1; write 0x08 = 32'h2 on same edge as another i_done → done stays 1; clean W1C → 0, o_irq = 0.
- Read 0x40, write 0x06, penable without setup → ERR_CNT = 3, read returned 0; write CTRL bit2 → ERR_CNT = 0.
- Assert i_rst_n low between setup and access of a write to 0x20 = 32'h1 → SCRATCH = 0 after reset, ERR_CNT = 1 if penable is high at release.
